ddr_burst_fill: RTL and testbench
=================================

// Module: ddr_burst_fill
// PURPOSE
//  Burst-read engine on the filling side of a 64-deep x 64-bit deq queue: reads a linear
//  region of DDR in bursts and pushes each returned word into the queue's enqueue port.
//  Credit-based: a burst is issued only when queue occupancy plus in-flight words leaves room,
//  so returned data is never refused. Sits between the DDR arbiter port and the queue feeding video/sprite logic.
// PARAMETERS
//  DATA_WIDTH   64  word width (bits); byte step per word = DATA_WIDTH/8
//  ADDR_WIDTH   32  DDR byte-address width
//  BURST_LEN    16  max words per burst (power of two, <= FIFO_DEPTH)
//  FIFO_DEPTH   64  capacity of the downstream queue
//  COUNT_WIDTH  7   width of io_fifo_count / outstanding counter (log2(FIFO_DEPTH)+1)
// PORTS
//  clock                 in   1   single clock domain
//  reset_n               in   1   asynchronous, active-low reset
//  io_start              in   1   pulse: begin a fill job (ignored unless idle)
//  io_base_addr          in   ADDR_WIDTH  job start byte address (low 3 bits forced 0)
//  io_num_words          in   20  job length in words; latched on io_start
//  io_flush              in   1   abort job; discard in-flight data
//  io_busy               out  1   high from accepted start until return to IDLE
//  io_done               out  1   1-cycle pulse: all words of job enqueued
//  io_overflow           out  1   sticky error: data returned while io_fifo_enq_ready low
//  io_ddr_rd             out  1   burst read request, held until accepted
//  io_ddr_addr           out  ADDR_WIDTH  burst start byte address
//  io_ddr_burst_length   out  8   words in this burst (1..BURST_LEN)
//  io_ddr_wait_req       in   1   request stall; rd accepted on cycle rd=1 & wait_req=0
//  io_ddr_valid          in   1   read data word valid
//  io_ddr_dout           in   DATA_WIDTH  read data
//  io_fifo_enq_valid     out  1   = io_ddr_valid unless discarding
//  io_fifo_enq_bits      out  DATA_WIDTH  = io_ddr_dout (combinational pass-through)
//  io_fifo_enq_ready     in   1   queue not full
//  io_fifo_count         in   COUNT_WIDTH  queue occupancy
// BEHAVIOUR
//  Reset: state IDLE; busy/done/overflow/ddr_rd/fifo_enq_valid=0; addr, burst_length, counters=0.
//  Regs: addr, remaining (20b), outstanding (COUNT_WIDTH), burst (8b).
//  States: IDLE, CHECK, REQ, DRAIN, DISCARD, DONE.
//  IDLE: io_start -> latch addr, remaining=num_words; num_words==0 -> DONE, else CHECK. busy=1 from next cycle.
//  CHECK: remaining==0 -> DRAIN. Else burst=min(BURST_LEN,remaining); if
//    fifo_count + outstanding + burst <= FIFO_DEPTH (COUNT_WIDTH+1-bit compare) -> REQ, else stay.
//  REQ: ddr_rd=1, addr/burst_length stable. On accept: addr += burst*DATA_WIDTH/8 (wraps mod 2^ADDR_WIDTH),
//    remaining -= burst, outstanding += burst -> CHECK. Earliest next request 2 cycles after accept.
//  Data path (any state): ddr_valid decrements outstanding; accept and valid same cycle -> +burst-1.
//    Latency ddr_valid -> enq_valid is 0 cycles. enq_valid & ~enq_ready -> overflow=1 (word lost), cleared only by reset.
//  DRAIN: outstanding==0 -> DONE. DONE: done=1 one cycle -> IDLE, busy=0.
//  Flush: in REQ, ddr_rd held until accepted (burst counted in outstanding), then DISCARD.
//    In CHECK/DRAIN -> DISCARD. In IDLE/DONE: no effect (DONE still pulses).
//  DISCARD: enq_valid=0; outstanding decrements on ddr_valid; outstanding==0 -> IDLE, no done pulse.
//  io_start while busy ignored. Outstanding never exceeds FIFO_DEPTH.
// TESTING
//  1 base=0x1000, num=40, queue drained fast -> bursts (0x1000,16),(0x1080,16),(0x1100,8); 40 enqs; done once.
//  2 num=64, queue never dequeued -> 4 bursts of 16, then no request; enq_ready never low on valid; overflow=0.
//  3 count=56, outstanding=0, burst 16 -> no rd; dequeue to 48 -> rd asserts within 2 cycles.
//  4 wait_req high 5 cycles during REQ -> rd/addr/len stable throughout; single accept counted.
//  5 flush mid-burst with 10 words outstanding -> 10 words dropped (enq_valid=0), IDLE, done=0, busy=0.
//  6 num=0 -> done pulse 2 cycles after start, no rd; reset_n low mid-job -> all outputs 0 immediately.

Source files
------------

// File: rtl/ddr_burst_fill.sv
// Purpose: burst-read a linear DDR region and push each returned word into a 64-deep queue.
// Latency: io_ddr_valid -> io_fifo_enq_valid is combinational (0 cycles); next request >= 2 cycles after accept.
// Backpressure: a burst is issued only when queue count + outstanding + burst fits; io_ddr_rd held through wait_req.
// Ports: clock/reset_n; io_start/io_base_addr/io_num_words/io_flush job control; io_busy/io_done/io_overflow status;
//        io_ddr_* burst request and returned data; io_fifo_enq_* queue enqueue port, io_fifo_count queue occupancy.
module ddr_burst_fill #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 32,
  parameter int BURST_LEN   = 16,
  parameter int FIFO_DEPTH  = 64,
  parameter int COUNT_WIDTH = 7
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   io_start,
  input  logic [ADDR_WIDTH-1:0]  io_base_addr,
  input  logic [19:0]            io_num_words,
  input  logic                   io_flush,
  output logic                   io_busy,
  output logic                   io_done,
  output logic                   io_overflow,
  output logic                   io_ddr_rd,
  output logic [ADDR_WIDTH-1:0]  io_ddr_addr,
  output logic [7:0]             io_ddr_burst_length,
  input  logic                   io_ddr_wait_req,
  input  logic                   io_ddr_valid,
  input  logic [DATA_WIDTH-1:0]  io_ddr_dout,
  output logic                   io_fifo_enq_valid,
  output logic [DATA_WIDTH-1:0]  io_fifo_enq_bits,
  input  logic                   io_fifo_enq_ready,
  input  logic [COUNT_WIDTH-1:0] io_fifo_count
);

  localparam int                    BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam logic [19:0]           BURST_LEN_R    = 20'(BURST_LEN);
  localparam logic [7:0]            BURST_LEN_B    = 8'(BURST_LEN);
  localparam logic [COUNT_WIDTH:0]  DEPTH_C        = (COUNT_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK     = ~ADDR_WIDTH'(BYTES_PER_WORD - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_DRAIN, S_DISCARD, S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [19:0]            remaining;
  logic [COUNT_WIDTH-1:0] outstanding;
  logic [7:0]             burst;
  logic                   overflow;
  logic                   flush_pend;

  logic [7:0]             burst_calc;
  logic [COUNT_WIDTH:0]   credit_need;
  logic                   room;
  logic                   accept;
  logic                   discard;
  logic                   ret_word;
  logic [COUNT_WIDTH-1:0] out_add;
  logic [COUNT_WIDTH-1:0] out_sub;

  // Credit test is done one bit wider than the counters so a full queue plus a
  // full burst cannot wrap and look like it fits.
  always_comb begin
    burst_calc  = (remaining >= BURST_LEN_R) ? BURST_LEN_B : remaining[7:0];
    credit_need = {1'b0, io_fifo_count} + {1'b0, outstanding} + (COUNT_WIDTH + 1)'(burst_calc);
    room        = (credit_need <= DEPTH_C);
    accept      = (state == S_REQ) && !io_ddr_wait_req;
    // A flush seen while a request is pending must drop data from then on,
    // even though the FSM only reaches DISCARD once the request is accepted.
    discard     = (state == S_DISCARD) || flush_pend;
    ret_word    = io_ddr_valid && (outstanding != '0);
    out_add     = accept   ? COUNT_WIDTH'(burst) : '0;
    out_sub     = ret_word ? COUNT_WIDTH'(1)     : '0;
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (io_start) state_nxt = (io_num_words == '0) ? S_DONE : S_CHECK;
      S_CHECK: begin
        if (io_flush)                state_nxt = S_DISCARD;
        else if (remaining == '0)    state_nxt = S_DRAIN;
        else if (room)               state_nxt = S_REQ;
      end
      S_REQ:     if (accept) state_nxt = (io_flush || flush_pend) ? S_DISCARD : S_CHECK;
      S_DRAIN: begin
        if (io_flush)                state_nxt = S_DISCARD;
        else if (outstanding == '0)  state_nxt = S_DONE;
      end
      S_DISCARD: if (outstanding == '0) state_nxt = S_IDLE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    io_busy           = (state != S_IDLE);
    io_done           = (state == S_DONE);
    io_ddr_rd         = (state == S_REQ);
    io_fifo_enq_valid = io_ddr_valid && !discard;
  end

  assign io_ddr_addr         = addr;
  assign io_ddr_burst_length = burst;
  assign io_fifo_enq_bits    = io_ddr_dout;
  assign io_overflow         = overflow;

  // Job address / length bookkeeping; burst is frozen while REQ is held.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr      <= '0;
      remaining <= '0;
      burst     <= '0;
    end else if ((state == S_IDLE) && io_start) begin
      addr      <= io_base_addr & ALIGN_MASK;
      remaining <= io_num_words;
    end else if (state == S_CHECK) begin
      burst     <= burst_calc;
    end else if (accept) begin
      addr      <= addr + ADDR_WIDTH'(burst) * ADDR_WIDTH'(BYTES_PER_WORD);
      remaining <= remaining - 20'(burst);
    end
  end

  // Outstanding words, flush memory and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      flush_pend  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      outstanding <= outstanding + out_add - out_sub;
      flush_pend  <= (state == S_REQ) && !accept && (flush_pend || io_flush);
      if (io_fifo_enq_valid && !io_fifo_enq_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_burst_fill.sv
// Randomized bench for ddr_burst_fill: job model predicts bursts and words, a DDR
// responder and queue model drive the DUT, and a negedge monitor scores outputs.
module tb_ddr_burst_fill;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        io_start, io_flush, io_busy, io_done, io_overflow;
  logic [31:0] io_base_addr, io_ddr_addr;
  logic [19:0] io_num_words;
  logic        io_ddr_rd, io_ddr_wait_req, io_ddr_valid;
  logic [7:0]  io_ddr_burst_length;
  logic [63:0] io_ddr_dout, io_fifo_enq_bits;
  logic        io_fifo_enq_valid, io_fifo_enq_ready;
  logic [6:0]  io_fifo_count;

  always #5 clock = ~clock;

  ddr_burst_fill #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LEN(16), .FIFO_DEPTH(64), .COUNT_WIDTH(7)) dut (
    .clock(clock), .reset_n(reset_n), .io_start(io_start), .io_base_addr(io_base_addr),
    .io_num_words(io_num_words), .io_flush(io_flush), .io_busy(io_busy), .io_done(io_done),
    .io_overflow(io_overflow), .io_ddr_rd(io_ddr_rd), .io_ddr_addr(io_ddr_addr),
    .io_ddr_burst_length(io_ddr_burst_length), .io_ddr_wait_req(io_ddr_wait_req),
    .io_ddr_valid(io_ddr_valid), .io_ddr_dout(io_ddr_dout), .io_fifo_enq_valid(io_fifo_enq_valid),
    .io_fifo_enq_bits(io_fifo_enq_bits), .io_fifo_enq_ready(io_fifo_enq_ready), .io_fifo_count(io_fifo_count)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; } burst_t;
  burst_t      exp_burst_q[$];
  logic [63:0] exp_word_q[$];
  logic [31:0] ddr_word_q[$];

  int n_checks = 0, n_fail = 0;
  int acc_cnt = 0, enq_cnt = 0, done_cnt = 0, ret_cnt = 0, drop_cnt = 0, out_model = 0, occ = 0;
  int s_acc, s_enq, s_done, s_ret, s_drop;
  int deq_pct = 100, deq_req = 0, wait_pct = 0, valid_pct = 100;
  bit force_wait = 0, ddr_hold = 0, ready_kill = 0, allow_ovf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hA5C3_5A3C, ~a + 32'h0F1E_2D3C};
  endfunction

  // Reference model: a job is a list of bursts of at most 16 words, 128 bytes apart,
  // and the queue receives the words of the region in address order.
  task automatic push_job(input logic [31:0] base, input int num);
    logic [31:0] a0;
    burst_t      b;
    a0 = base & 32'hFFFF_FFF8;
    for (int k = 0; k < num; k += 16) begin
      b.addr = a0 + 32'(k * 8);
      b.len  = 8'(((num - k) < 16) ? (num - k) : 16);
      exp_burst_q.push_back(b);
    end
    for (int i = 0; i < num; i++) exp_word_q.push_back(mem_word(a0 + 32'(i * 8)));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_job(input logic [31:0] base, input int num);
    push_job(base, num);
    io_base_addr = base;
    io_num_words = 20'(num);
    io_start     = 1'b1;
    tick();
    io_start     = 1'b0;
  endtask

  task automatic snap();
    s_acc = acc_cnt; s_enq = enq_cnt; s_done = done_cnt; s_ret = ret_cnt; s_drop = drop_cnt;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (io_busy && n < bound) begin tick(); n++; end
    chk("idle_reached", io_busy, 0);
  endtask

  task automatic wait_rd(input int bound);
    int n = 0;
    while (!io_ddr_rd && n < bound) begin tick(); n++; end
    chk("rd_seen", io_ddr_rd, 1);
  endtask

  task automatic wait_acc(input int target, input int bound);
    int n = 0;
    while (acc_cnt < target && n < bound) begin tick(); n++; end
    chk("accept_seen", acc_cnt >= target, 1);
  endtask

  task automatic end_checks(input string tag, input int nb, input int nw, input int nd);
    chk({tag, "_bursts"}, acc_cnt - s_acc, nb);
    chk({tag, "_enqs"}, enq_cnt - s_enq, nw);
    chk({tag, "_done"}, done_cnt - s_done, nd);
    chk({tag, "_words_left"}, exp_word_q.size(), 0);
    chk({tag, "_bursts_left"}, exp_burst_q.size(), 0);
    chk({tag, "_outstanding"}, out_model, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, io_busy, 0);
    chk({tag, "_done"}, io_done, 0);
    chk({tag, "_overflow"}, io_overflow, 0);
    chk({tag, "_rd"}, io_ddr_rd, 0);
    chk({tag, "_addr"}, io_ddr_addr, 0);
    chk({tag, "_len"}, io_ddr_burst_length, 0);
    chk({tag, "_enq_valid"}, io_fifo_enq_valid, 0);
  endtask

  // Monitor: samples on the falling edge, scores bursts and enqueued words.
  always @(negedge clock) begin : monitor
    burst_t b;
    if (reset_n) begin
      if (io_ddr_rd && !io_ddr_wait_req) begin
        acc_cnt++;
        chk("credit", (occ + out_model + int'(io_ddr_burst_length)) <= 64, 1);
        chk("burst_expected", exp_burst_q.size() != 0, 1);
        if (exp_burst_q.size() != 0) begin
          b = exp_burst_q.pop_front();
          chk("burst_addr", io_ddr_addr, b.addr);
          chk("burst_len", io_ddr_burst_length, b.len);
        end
        for (int i = 0; i < int'(io_ddr_burst_length); i++) ddr_word_q.push_back(io_ddr_addr + 32'(i * 8));
        out_model += int'(io_ddr_burst_length);
      end
      if (io_ddr_valid) begin
        ret_cnt++;
        out_model--;
        if (!io_fifo_enq_valid) drop_cnt++;
      end
      if (io_fifo_enq_valid) begin
        enq_cnt++;
        if (!allow_ovf) chk("enq_ready", io_fifo_enq_ready, 1);
        chk("enq_expected", exp_word_q.size() != 0, 1);
        if (exp_word_q.size() != 0) chk("enq_data", io_fifo_enq_bits, exp_word_q.pop_front());
      end
      if (io_done) done_cnt++;
    end
  end

  // Downstream queue model: occupancy, not-full ready, random or counted dequeues.
  initial begin : fifo_model
    bit e, d;
    io_fifo_count     = '0;
    io_fifo_enq_ready = 1'b1;
    forever begin
      @(negedge clock);
      e = io_fifo_enq_valid && io_fifo_enq_ready;
      @(posedge clock);
      #2;
      d = (occ > 0) && ((deq_req > 0) || ($urandom_range(99) < deq_pct));
      if (d && deq_req > 0) deq_req--;
      occ = occ + int'(e) - int'(d);
      io_fifo_count     = 7'(occ);
      io_fifo_enq_ready = !ready_kill && (occ < 64);
    end
  end

  // DDR responder: random wait_req, returns accepted words in order with random gaps.
  initial begin : ddr_model
    io_ddr_wait_req = 1'b0;
    io_ddr_valid    = 1'b0;
    io_ddr_dout     = '0;
    forever begin
      @(posedge clock);
      #2;
      io_ddr_wait_req = force_wait || ($urandom_range(99) < wait_pct);
      if (reset_n && !ddr_hold && ddr_word_q.size() != 0 && $urandom_range(99) < valid_pct) begin
        io_ddr_valid = 1'b1;
        io_ddr_dout  = mem_word(ddr_word_q.pop_front());
      end else begin
        io_ddr_valid = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int          num, n;
    logic [31:0] base;
    reset_n = 1'b0; io_start = 1'b0; io_flush = 1'b0; io_base_addr = '0; io_num_words = '0;
    repeat (3) @(posedge clock);
    #1;
    chk_zero_outputs("reset");
    reset_n = 1'b1;
    tick(); tick();

    // Fast drain, three bursts of 16/16/8.
    snap();
    start_job(32'h0000_1000, 40);
    wait_idle(500);
    end_checks("t1", 3, 40, 1);

    // Queue never dequeued: exactly four bursts fill it to 64.
    deq_pct = 0;
    snap();
    start_job(32'h0020_0000, 64);
    wait_idle(500);
    end_checks("t2", 4, 64, 1);
    chk("t2_occ", occ, 64);
    chk("t2_overflow", io_overflow, 0);

    // Credit hold at 56, release at 48.
    deq_req = 8;
    n = 0;
    while (deq_req > 0 && n < 40) begin tick(); n++; end
    chk("t3_occ56", occ, 56);
    snap();
    start_job(32'h0000_2000, 16);
    repeat (20) tick();
    chk("t3_rd_held", io_ddr_rd, 0);
    chk("t3_no_accept", acc_cnt - s_acc, 0);
    deq_req = 8;
    n = 0;
    while (deq_req > 0 && n < 40) begin tick(); n++; end
    n = 0;
    while (!io_ddr_rd && n < 4) begin tick(); n++; end
    chk("t3_rd_latency", n <= 2, 1);
    deq_pct = 100;
    wait_idle(500);
    end_checks("t3", 1, 16, 1);

    // Randomized jobs, including an address-wrapping region and an ignored restart.
    for (int j = 0; j < 8; j++) begin
      base      = (j == 0) ? 32'hFFFF_FF40 : $urandom;
      num       = $urandom_range(100, 1);
      deq_pct   = $urandom_range(100, 20);
      wait_pct  = $urandom_range(60, 0);
      valid_pct = $urandom_range(100, 30);
      snap();
      start_job(base, num);
      repeat (3) tick();
      if (io_busy) begin
        io_base_addr = $urandom;
        io_num_words = 20'd5;
        io_start     = 1'b1;
        tick();
        io_start     = 1'b0;
      end
      wait_idle(5000);
      end_checks("rand", (num + 15) / 16, num, 1);
    end
    deq_pct = 100; wait_pct = 0; valid_pct = 100;
    repeat (5) tick();

    // Request held under wait_req, then flushed while still requesting.
    force_wait = 1; ddr_hold = 1;
    snap();
    start_job(32'h0004_0000, 40);
    wait_rd(10);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t4_rd_held", io_ddr_rd, 1);
      chk("t4_addr_stable", io_ddr_addr, 32'h0004_0000);
      chk("t4_len_stable", io_ddr_burst_length, 16);
    end
    chk("t4_no_accept_yet", acc_cnt - s_acc, 0);
    io_flush = 1'b1;
    tick();
    io_flush = 1'b0;
    force_wait = 0;
    wait_acc(s_acc + 1, 10);
    tick();
    exp_burst_q.delete();
    exp_word_q.delete();
    ddr_hold = 0;
    wait_idle(200);
    chk("t4_one_accept", acc_cnt - s_acc, 1);
    chk("t4_no_enq", enq_cnt - s_enq, 0);
    chk("t4_dropped", drop_cnt - s_drop, 16);
    chk("t4_no_done", done_cnt - s_done, 0);
    chk("t4_outstanding", out_model, 0);

    // Flush while draining with 10 words outstanding.
    ddr_hold = 1;
    snap();
    start_job(32'h0005_0000, 10);
    wait_acc(s_acc + 1, 20);
    repeat (2) tick();
    chk("t5_outstanding10", out_model, 10);
    io_flush = 1'b1;
    tick();
    io_flush = 1'b0;
    exp_word_q.delete();
    ddr_hold = 0;
    wait_idle(200);
    chk("t5_no_enq", enq_cnt - s_enq, 0);
    chk("t5_dropped", drop_cnt - s_drop, 10);
    chk("t5_returned", ret_cnt - s_ret, 10);
    chk("t5_no_done", done_cnt - s_done, 0);

    // Zero-length job: done pulse, no request.
    snap();
    start_job(32'h0000_0100, 0);
    n = 0;
    while (!io_done && n < 3) begin tick(); n++; end
    chk("t6_done_seen", io_done, 1);
    chk("t6_done_latency", n <= 1, 1);
    tick();
    chk("t6_done_width", io_done, 0);
    wait_idle(20);
    end_checks("t6", 0, 0, 1);

    // Word returned while the queue refuses it: sticky overflow.
    ready_kill = 1; allow_ovf = 1;
    snap();
    start_job(32'h0006_0000, 1);
    wait_idle(100);
    end_checks("ovf", 1, 1, 1);
    chk("ovf_set", io_overflow, 1);
    repeat (3) tick();
    chk("ovf_sticky", io_overflow, 1);
    ready_kill = 0; allow_ovf = 0;

    // Asynchronous reset in the middle of a request.
    force_wait = 1; ddr_hold = 1;
    start_job(32'h0000_7000, 30);
    wait_rd(10);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    exp_burst_q.delete(); exp_word_q.delete(); ddr_word_q.delete();
    out_model = 0; force_wait = 0; ddr_hold = 0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("post_reset_idle", io_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
